// File: rtl/mem_access_if.sv
// ---------------------------------------------------------------------------
// mem_access_if -- data-bus bundle between the MEM stage and the data memory.
//
// Signals:
//   bus_req    master -> slave  transaction request
//   bus_we     master -> slave  1 store, 0 load
//   bus_addr   master -> slave  word-aligned byte address
//   bus_sel    master -> slave  byte-lane enables (lane k = bits [8k+7:8k])
//   bus_wdata  master -> slave  lane-replicated store data
//   bus_rdata  slave -> master  read data, meaningful only with bus_ack
//   bus_ack    slave -> master  transaction complete
//
// Handshake: the master raises bus_req and holds it, together with addr/we/
// sel/wdata, stable until it samples bus_ack high on a rising edge; that edge
// completes the transfer and bus_req drops on the following cycle. bus_ack is
// a single-cycle completion strobe and is ignored while bus_req is low. The
// master may also abandon a pending request (reset or timeout), after which a
// late ack is ignored.
// ---------------------------------------------------------------------------
interface mem_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- MEM-stage engine of the RISC-V pipeline.
//
// Non-memory ops pass straight through to MEM/WB. Aligned loads/stores run one
// request/ack transaction on the data bus while the pipeline is stalled;
// load data is lane-aligned and sign/zero extended in the single DONE cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ex_waddr/ex_we/ex_wdata  write-back triple from EX/MEM
//   ex_memop                 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU,
//                            6 SB, 7 SH, 8 SW, 9-15 none
//   ex_maddr, ex_sdata       effective byte address, store source data
//   mem_waddr/mem_we/mem_wdata  write-back triple to MEM/WB
//   stall_req                hold the upstream pipeline (inputs stay stable)
//   exc_misalign             misaligned access flag (IDLE only)
//   bus_err                  one-cycle pulse when a transaction times out
//   bus                      data bus (mem_access_if.master)
//
// Parameter TIMEOUT: BUSY cycles without ack before abort (0 = never).
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         ex_waddr,
    input  logic               ex_we,
    input  logic [31:0]        ex_wdata,
    input  logic [3:0]         ex_memop,
    input  logic [31:0]        ex_maddr,
    input  logic [31:0]        ex_sdata,
    output logic [4:0]         mem_waddr,
    output logic               mem_we,
    output logic [31:0]        mem_wdata,
    output logic               stall_req,
    output logic               exc_misalign,
    output logic               bus_err,
    mem_access_if.master       bus
);
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bus_req_q;

    // ---------------- op decode ----------------
    logic is_load, is_store, is_byte, is_half, is_word;
    logic is_mem, misaligned, go, timeout_hit;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (ex_memop)
            4'd1, 4'd4: begin is_load  = 1'b1; is_byte = 1'b1; end
            4'd2, 4'd5: begin is_load  = 1'b1; is_half = 1'b1; end
            4'd3:       begin is_load  = 1'b1; is_word = 1'b1; end
            4'd6:       begin is_store = 1'b1; is_byte = 1'b1; end
            4'd7:       begin is_store = 1'b1; is_half = 1'b1; end
            4'd8:       begin is_store = 1'b1; is_word = 1'b1; end
            default:    ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = (is_half & ex_maddr[0]) | (is_word & (|ex_maddr[1:0]));
    assign go         = (state == IDLE) && is_mem && !misaligned;
    // The abort fires in the TIMEOUT-th BUSY cycle without ack; an ack in
    // that same cycle wins because it is tested first in the FSM.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            bus_req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state     <= BUSY;
                        bus_req_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                BUSY: begin
                    if (bus.bus_ack) begin
                        rdata_q   <= bus.bus_rdata;
                        state     <= DONE;
                        bus_req_q <= 1'b0;
                    end else if (timeout_hit) begin
                        err_q     <= 1'b1;
                        state     <= DONE;
                        bus_req_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    err_q <= 1'b0;
                    cnt_q <= '0;
                end
                default: begin
                    state     <= IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- bus side ----------------
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;

    always_comb begin
        lane_sel   = 4'b0000;
        lane_wdata = ex_sdata;
        if (is_byte) begin
            lane_sel   = 4'b0001 << ex_maddr[1:0];
            lane_wdata = {4{ex_sdata[7:0]}};
        end else if (is_half) begin
            lane_sel   = ex_maddr[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{ex_sdata[15:0]}};
        end else if (is_word) begin
            lane_sel   = 4'b1111;
        end
    end

    // bus_req_q is high exactly while the FSM is in BUSY.
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_req_q & is_store;
    assign bus.bus_sel   = bus_req_q ? lane_sel : 4'b0000;
    assign bus.bus_addr  = {ex_maddr[31:2], 2'b00};
    assign bus.bus_wdata = lane_wdata;

    // ---------------- load alignment / extension ----------------
    logic [31:0] rdata_shift;
    logic [15:0] rhalf;
    logic [7:0]  rbyte;
    logic [31:0] ld_val;

    assign rdata_shift = rdata_q >> {ex_maddr[1:0], 3'b000};
    assign rbyte       = rdata_shift[7:0];
    assign rhalf       = ex_maddr[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        case (ex_memop)
            4'd1:    ld_val = {{24{rbyte[7]}}, rbyte};
            4'd2:    ld_val = {{16{rhalf[15]}}, rhalf};
            4'd4:    ld_val = {24'h0, rbyte};
            4'd5:    ld_val = {16'h0, rhalf};
            default: ld_val = rdata_q;
        endcase
    end

    // ---------------- pipeline side ----------------
    always_comb begin
        mem_waddr = ex_waddr;
        mem_we    = 1'b0;
        mem_wdata = ex_wdata;
        if (rst) begin
            mem_waddr = '0;
            mem_wdata = '0;
        end else begin
            case (state)
                IDLE: mem_we = ex_we & ~is_mem;
                DONE: begin
                    if (is_load) begin
                        mem_we    = ex_we & ~err_q;
                        mem_wdata = ld_val;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_req    = !rst && (go || state == BUSY);
    assign exc_misalign = !rst && (state == IDLE) && is_mem && misaligned;
    // err_q only lives for the DONE cycle, so this is a single-cycle pulse.
    assign bus_err      = err_q;
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage engine of the RISC-V pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Non-memory instructions pass straight through as write-back triples (waddr/we/wdata).
- Loads and stores run a request/acknowledge transaction on the data bus. The FSM stalls the pipeline until the transaction completes. Load data is aligned and extended, then handed to MEM/WB.

Parameters:
- TIMEOUT, 255, max BUSY cycles without bus_ack before abort; 0 disables timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_waddr  in  5  destination register
- ex_we  in  1  register write enable
- ex_wdata  in  32  ALU result (write-back value for non-memory ops)
- ex_memop  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as none
- ex_maddr  in  32  effective byte address
- ex_sdata  in  32  store source data
- mem_waddr  out  5  to MEM/WB
- mem_we  out  1  to MEM/WB
- mem_wdata  out  32  to MEM/WB
- stall_req  out  1  hold PC/IF/ID/EX/EX-MEM; upstream inputs stay stable while high
- exc_misalign  out  1  misaligned access flag
- bus_err  out  1  one-cycle pulse on timeout
- bus_req  out  1  bus request
- bus_we  out  1  1 store, 0 load
- bus_addr  out  32  {ex_maddr[31:2],2'b00}
- bus_sel  out  4  byte-lane enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid when bus_ack
- bus_ack  in  1  transaction complete

Behaviour:
- FSM states: IDLE, BUSY, DONE. Registers: state, rdata_q (32), err_q, timeout counter (8+ bits).
- Reset (asynchronous):
  - state=IDLE, counter=0, rdata_q=0, err_q=0.
  - bus_req=0, bus_err=0, stall_req=0.
  - With reset asserted, mem_we=0, mem_waddr=0, mem_wdata=0.
  - Reset during BUSY drops bus_req immediately; the transaction is abandoned.
- Non-memory op in IDLE:
  - mem_waddr=ex_waddr, mem_we=ex_we, mem_wdata=ex_wdata, combinationally.
  - stall_req=0; no state change.
- Alignment:
  - LH, LHU and SH require addr[0]=0. LW and SW require addr[1:0]=0.
  - Misaligned op in IDLE: exc_misalign=1, mem_we=0, stall_req=0, no bus access, state stays IDLE.
- Aligned memory op:
  - IDLE: stall_req=1, mem_we=0; next state BUSY.
  - BUSY: bus_req=1, stall_req=1, mem_we=0. bus_addr, bus_we, bus_sel and bus_wdata are derived from the held inputs.
  - BUSY + bus_ack=1: capture bus_rdata into rdata_q; next state DONE.
- Timeout:
  - Counter counts BUSY cycles without ack.
  - Reaching TIMEOUT with no ack: set err_q, pulse bus_err for one cycle, next state DONE.
  - Ack in the same cycle the counter reaches TIMEOUT counts as success.
- DONE (exactly one cycle):
  - stall_req=0.
  - Load: mem_we=ex_we & ~err_q, mem_waddr=ex_waddr, mem_wdata=extended rdata_q.
  - Store: mem_we=0.
  - Next state IDLE; err_q and counter clear.
- Minimum latency: load/store occupies 3 cycles (IDLE detect, BUSY with same-cycle ack, DONE).
- Byte lanes, little-endian:
  - Lane k = addr[1:0] occupies bits [8k+7:8k].
  - SB: sel=1<<k, wdata={4{sdata[7:0]}}.
  - SH: sel=addr[1]?4'b1100:4'b0011, wdata={2{sdata[15:0]}}.
  - SW: sel=4'b1111.
  - Loads drive sel the same way.
- Load extension: LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes through.
- Outside BUSY: bus_req=0, bus_sel=0, bus_we=0.
- bus_ack outside BUSY is ignored.
- exc_misalign=0 outside IDLE.

Test Plan:
1. ALU pass-through: memop=0, waddr=5, we=1, wdata=0x1234 -> same cycle mem_* = {5,1,0x1234}, stall_req=0, bus_req never asserts.
2. LB with sign extension: addr=0x1003, ack in first BUSY cycle with rdata=0x80FF_FFFF -> bus_addr=0x1000, sel=4'b1000; DONE cycle mem_wdata=0xFFFF_FF80, mem_we=1; stall high exactly 2 cycles.
3. LHU with 3-cycle ack delay: addr=0x2002, rdata=0xBEEF_0000 -> bus_req high 3 cycles, sel=4'b1100; DONE mem_wdata=0x0000_BEEF.
4. SB: addr=0x3001, sdata=0xAB -> bus_we=1, sel=4'b0010, wdata=0xABABABAB; DONE mem_we=0.
5. SW at addr=0x4002 -> exc_misalign=1, stall_req=0, bus_req stays 0, mem_we=0.
6. LW, TIMEOUT=4, no ack -> bus_req high 4 cycles, then bus_err pulses, DONE with mem_we=0. Repeat with rst asserted mid-BUSY -> bus_req=0 and stall_req=0 immediately, state returns to IDLE.
